// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit: states,
// opcode constants, opcode classes, aluop and pc_src encodings.
package mc_ctrl_pkg;

   localparam int unsigned STATE_W      = 4;
   localparam int unsigned OPC_BASE_W   = 4;
   localparam int unsigned OPCLASS_W    = 3;
   localparam int unsigned ALUOP_BASE_W = 2;
   localparam int unsigned PCSRC_W      = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMACC = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9
   } state_t;

   typedef enum logic [OPCLASS_W-1:0] {
      OP_LW      = 3'd0,
      OP_SW      = 3'd1,
      OP_DP      = 3'd2,
      OP_BEQ     = 3'd3,
      OP_BNE     = 3'd4,
      OP_JMP     = 3'd5,
      OP_ILLEGAL = 3'd6
   } op_class_t;

   localparam logic [OPC_BASE_W-1:0] OPC_LW    = 4'd0;
   localparam logic [OPC_BASE_W-1:0] OPC_SW    = 4'd1;
   localparam logic [OPC_BASE_W-1:0] OPC_DP_LO = 4'd2;
   localparam logic [OPC_BASE_W-1:0] OPC_DP_HI = 4'd9;
   localparam logic [OPC_BASE_W-1:0] OPC_BEQ   = 4'd11;
   localparam logic [OPC_BASE_W-1:0] OPC_BNE   = 4'd12;
   localparam logic [OPC_BASE_W-1:0] OPC_JMP   = 4'd13;

   localparam logic [ALUOP_BASE_W-1:0] ALUOP_RTYPE = 2'b00;
   localparam logic [ALUOP_BASE_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_BASE_W-1:0] ALUOP_ADD   = 2'b10;

   localparam logic [PCSRC_W-1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode -> opcode-class decoder. Any set bit above bit 3
// makes the opcode illegal.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   output op_class_t           op_class
);

   logic [OPC_BASE_W-1:0] opc_lo;
   logic                  hi_ok;

   assign opc_lo = opcode[OPC_BASE_W-1:0];
   assign hi_ok  = ((opcode >> OPC_BASE_W) == '0);

   always_comb begin
      op_class = OP_ILLEGAL;
      if (hi_ok) begin
         if (opc_lo == OPC_LW)                               op_class = OP_LW;
         else if (opc_lo == OPC_SW)                          op_class = OP_SW;
         else if (opc_lo >= OPC_DP_LO && opc_lo <= OPC_DP_HI) op_class = OP_DP;
         else if (opc_lo == OPC_BEQ)                         op_class = OP_BEQ;
         else if (opc_lo == OPC_BNE)                         op_class = OP_BNE;
         else if (opc_lo == OPC_JMP)                         op_class = OP_JMP;
      end
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle processor control FSM (Moore outputs; BRANCH pc_write uses zero).
// Optional memory stall handshake on FETCH/MEMACC enabled by MC_CTRL_STALL_EN.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned ALUOP_W  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                alu_src,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic [PCSRC_W-1:0]  pc_src,
   output logic [ALUOP_W-1:0]  aluop,
   output logic                illegal_op,
   output logic                instr_done,
   output logic [STATE_W-1:0]  state_o
);

   state_t    state_q, state_d;
   op_class_t op_q, dec_class;
   logic      mem_done;

   mc_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode   (opcode),
      .op_class (dec_class)
   );

`ifdef MC_CTRL_STALL_EN
   assign mem_done = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_done         = 1'b1;
`endif

   // State and latched opcode class; op_q is only captured while in DECODE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         op_q    <= OP_ILLEGAL;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DECODE) op_q <= dec_class;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_src     = PCSRC_SEQ;
      aluop      = ALUOP_W'(ALUOP_RTYPE);
      illegal_op = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         ST_INIT:   state_d = ST_FETCH;
         ST_FETCH: begin
            mem_read = 1'b1;
            ir_write = mem_done;
            pc_write = mem_done;
            if (mem_done) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (dec_class)
               OP_LW, OP_SW:   state_d = ST_MEMADR;
               OP_DP:          state_d = ST_EXEC;
               OP_BEQ, OP_BNE: state_d = ST_BRANCH;
               OP_JMP:         state_d = ST_JUMP;
               default: begin
                  state_d    = ST_FETCH;
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         ST_MEMADR: begin
            alu_src = 1'b1;
            aluop   = ALUOP_W'(ALUOP_ADD);
            state_d = ST_MEMACC;
         end
         ST_MEMACC: begin
            if (op_q == OP_SW) begin
               mem_write  = 1'b1;
               instr_done = mem_done;
               if (mem_done) state_d = ST_FETCH;
            end else begin
               mem_read = 1'b1;
               if (mem_done) state_d = ST_MEMWB;
            end
         end
         ST_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_EXEC:   state_d = ST_ALUWB;
         ST_ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_BRANCH: begin
            aluop      = ALUOP_W'(ALUOP_SUB);
            pc_src     = PCSRC_BRANCH;
            instr_done = 1'b1;
            pc_write   = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
            state_d    = ST_FETCH;
         end
         ST_JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end
         default:   state_d = ST_INIT;
      endcase
   end

   assign state_o = state_q;

endmodule
